data_mover_bram_ch: RTL and testbench

Second-generation BRAM-to-BRAM data mover. It reads `i_num_cnt` words from source BRAM0 starting at a programmable base address. Each word passes through a fixed-latency core pipeline that applies a selectable per-word operation, and the result is written to destination BRAM1 at a programmable base address. It sits behind the control register block, driven by a run pulse, and reports idle/read/write/done status.

---
 rtl/data_mover_bram_ch.sv | 156 +++++++++++++++
 tb/tb_data_mover_bram_ch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mover_bram_ch.sv
// rtl/data_mover_bram_ch.sv - BRAM0-to-BRAM1 data mover with a fixed-latency per-word operation pipeline.
// Optional cycle counter output o_cycle_cnt is enabled by defining DM_PERF_CNT_EN.
module data_mover_bram_ch #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 12,
    parameter int CORE_DELAY = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run,
    input  logic [AWIDTH:0]   i_num_cnt,
    input  logic [AWIDTH-1:0] i_src_base,
    input  logic [AWIDTH-1:0] i_dst_base,
    input  logic [1:0]        i_mode,
    input  logic [DWIDTH-1:0] i_operand,
    output logic              o_idle,
    output logic              o_read,
    output logic              o_write,
    output logic              o_done,
    output logic [AWIDTH-1:0] addr_b0,
    output logic              ce_b0,
    output logic              we_b0,
    output logic [DWIDTH-1:0] d_b0,
    input  logic [DWIDTH-1:0] q_b0,
    output logic [AWIDTH-1:0] addr_b1,
    output logic              ce_b1,
    output logic              we_b1,
    output logic [DWIDTH-1:0] d_b1,
    input  logic [DWIDTH-1:0] q_b1
`ifdef DM_PERF_CNT_EN
    ,
    output logic [31:0]       o_cycle_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AWIDTH:0] ONE     = (AWIDTH+1)'(1);
    localparam logic [AWIDTH:0] MAX_CNT = ONE << AWIDTH;

    state_t              state;
    state_t              state_n;
    logic [AWIDTH:0]     cnt_r;
    logic [AWIDTH-1:0]   src_r;
    logic [AWIDTH-1:0]   dst_r;
    logic [1:0]          mode_r;
    logic [DWIDTH-1:0]   operand_r;
    logic [AWIDTH:0]     rd_idx;
    logic [AWIDTH:0]     wr_idx;
    logic                rd_pend;
    logic [CORE_DELAY-1:0] pipe_valid;
    logic [DWIDTH-1:0]   pipe_data [CORE_DELAY];
    logic [AWIDTH:0]     cnt_in;
    logic                accept;
    logic                unused_q_b1;

    assign unused_q_b1 = ^q_b1;

    assign cnt_in = (i_num_cnt > MAX_CNT) ? MAX_CNT : i_num_cnt;
    assign accept = (state == S_IDLE) && i_run;

    function automatic logic [DWIDTH-1:0] word_op(input logic [1:0] m,
                                                  input logic [DWIDTH-1:0] a,
                                                  input logic [DWIDTH-1:0] b);
        case (m)
            2'b00:   word_op = a;
            2'b01:   word_op = a + b;
            2'b10:   word_op = a ^ b;
            default: word_op = ~a;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (i_run) state_n = (cnt_in == '0) ? S_DONE : S_READ;
            S_READ:  if (rd_idx == cnt_r - ONE) state_n = S_DRAIN;
            S_DRAIN: if (pipe_valid[CORE_DELAY-1] && (wr_idx == cnt_r - ONE)) state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    // Configuration is frozen at acceptance so mid-transfer input changes have no effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= '0;
            src_r     <= '0;
            dst_r     <= '0;
            mode_r    <= '0;
            operand_r <= '0;
        end else if (accept) begin
            cnt_r     <= cnt_in;
            src_r     <= i_src_base;
            dst_r     <= i_dst_base;
            mode_r    <= i_mode;
            operand_r <= i_operand;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || accept) rd_idx <= '0;
        else if (state == S_READ) rd_idx <= rd_idx + ONE;
    end

    always_ff @(posedge clk) begin
        if (reset || (state == S_DONE)) wr_idx <= '0;
        else if (pipe_valid[CORE_DELAY-1]) wr_idx <= wr_idx + ONE;
    end

    // rd_pend marks the cycle in which q_b0 carries the word requested one cycle earlier.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend    <= 1'b0;
            pipe_valid <= '0;
            for (int i = 0; i < CORE_DELAY; i++) pipe_data[i] <= '0;
        end else begin
            rd_pend      <= (state == S_READ);
            pipe_valid   <= {pipe_valid[CORE_DELAY-2:0], rd_pend};
            pipe_data[0] <= word_op(mode_r, q_b0, operand_r);
            for (int i = 1; i < CORE_DELAY; i++) pipe_data[i] <= pipe_data[i-1];
        end
    end

`ifdef DM_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || accept) o_cycle_cnt <= '0;
        else if ((state != S_IDLE) && (o_cycle_cnt != 32'hFFFF_FFFF)) o_cycle_cnt <= o_cycle_cnt + 32'd1;
    end
`endif

    assign o_idle  = (state == S_IDLE);
    assign o_read  = (state == S_READ);
    assign o_write = (state == S_READ) || (state == S_DRAIN);
    assign o_done  = (state == S_DONE);

    assign ce_b0   = (state == S_READ);
    assign addr_b0 = ce_b0 ? (src_r + rd_idx[AWIDTH-1:0]) : '0;
    assign we_b0   = 1'b0;
    assign d_b0    = '0;

    assign we_b1   = pipe_valid[CORE_DELAY-1];
    assign ce_b1   = we_b1;
    assign addr_b1 = we_b1 ? (dst_r + wr_idx[AWIDTH-1:0]) : '0;
    assign d_b1    = we_b1 ? pipe_data[CORE_DELAY-1] : '0;

endmodule

// File: tb/tb_data_mover_bram_ch.sv
// tb/tb_data_mover_bram_ch.sv - randomized self-checking bench for data_mover_bram_ch against a cycle-table model.
module tb_data_mover_bram_ch;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int D  = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_run = 1'b0;
    logic [AW:0]   i_num_cnt = '0;
    logic [AW-1:0] i_src_base = '0;
    logic [AW-1:0] i_dst_base = '0;
    logic [1:0]    i_mode = '0;
    logic [DW-1:0] i_operand = '0;
    logic          o_idle, o_read, o_write, o_done;
    logic [AW-1:0] addr_b0, addr_b1;
    logic          ce_b0, we_b0, ce_b1, we_b1;
    logic [DW-1:0] d_b0, d_b1;
    logic [DW-1:0] q_b0 = '0;
    logic [DW-1:0] q_b1 = '0;
`ifdef DM_PERF_CNT_EN
    logic [31:0]   o_cycle_cnt;
`endif

    logic [DW-1:0] bram0 [DEPTH];
    logic [DW-1:0] bram1 [DEPTH];
    int            wr_cnt [DEPTH];
    int            checks = 0;
    int            errors = 0;

    data_mover_bram_ch #(.DWIDTH(DW), .AWIDTH(AW), .CORE_DELAY(D)) dut (
        .clk(clk), .reset(reset), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .i_src_base(i_src_base), .i_dst_base(i_dst_base), .i_mode(i_mode),
        .i_operand(i_operand), .o_idle(o_idle), .o_read(o_read), .o_write(o_write),
        .o_done(o_done), .addr_b0(addr_b0), .ce_b0(ce_b0), .we_b0(we_b0),
        .d_b0(d_b0), .q_b0(q_b0), .addr_b1(addr_b1), .ce_b1(ce_b1), .we_b1(we_b1),
        .d_b1(d_b1), .q_b1(q_b1)
`ifdef DM_PERF_CNT_EN
        , .o_cycle_cnt(o_cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ce_b0) q_b0 <= bram0[addr_b0];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input int mode, input logic [31:0] a, input logic [31:0] b);
        case (mode)
            0:       return a;
            1:       return a + b;
            2:       return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // Cycle 0 is the acceptance cycle; every later cycle is compared against the transfer's timing table.
    task automatic run_xfer(input int n_raw, input int src, input int dst, input int mode,
                            input logic [31:0] opnd, input int busy_at, input int abort_at);
        int n, last, k;
        logic rexp, wexp;
        n    = (n_raw > DEPTH) ? DEPTH : n_raw;
        last = (n == 0) ? 1 : n + D + 2;
        @(negedge clk);
        check("idle_before_run", o_idle, 1);
        i_run      = 1'b1;
        i_num_cnt  = (AW+1)'(n_raw);
        i_src_base = AW'(src);
        i_dst_base = AW'(dst);
        i_mode     = 2'(mode);
        i_operand  = opnd;
        @(negedge clk);
        for (int c = 1; c <= last + 1; c++) begin
            i_run      = (c == busy_at);
            i_num_cnt  = (AW+1)'($urandom_range(1, 3));
            i_src_base = AW'($urandom);
            i_dst_base = AW'($urandom);
            i_mode     = 2'($urandom);
            i_operand  = $urandom;
            if (abort_at > 0 && c > abort_at) begin
                check("abort_no_write", ce_b1, 0);
                check("abort_no_read", ce_b0, 0);
                check("abort_no_done", o_done, 0);
                check("abort_idle", o_idle, 1);
                if (c == abort_at + 3) begin
                    reset = 1'b0;
                    i_run = 1'b0;
                    break;
                end
            end else begin
                rexp = (c <= n);
                wexp = (n > 0) && (c >= D + 2) && (c <= n + D + 1);
                k    = c - D - 2;
                check("ce_b0", ce_b0, rexp);
                if (rexp) check("addr_b0", addr_b0, (src + c - 1) % DEPTH);
                check("we_b1", we_b1, wexp);
                check("ce_b1_eq_we_b1", ce_b1, we_b1);
                if (wexp) begin
                    check("addr_b1", addr_b1, (dst + k) % DEPTH);
                    check("d_b1", d_b1, ref_op(mode, bram0[(src + k) % DEPTH], opnd));
                end
                check("b0_write_port", {we_b0, d_b0}, 0);
                check("o_read", o_read, rexp);
                check("o_write", o_write, (n > 0) && (c <= n + D + 1));
                check("o_done", o_done, c == last);
                check("o_idle", o_idle, c == last + 1);
`ifdef DM_PERF_CNT_EN
                if (c == last + 1) check("cycle_cnt", o_cycle_cnt, last);
`endif
            end
            if (we_b1) begin
                bram1[addr_b1] = d_b1;
                wr_cnt[addr_b1]++;
            end
            if (c == abort_at) reset = 1'b1;
            @(negedge clk);
        end
        i_run = 1'b0;
    endtask

    task automatic clear_wr_cnt();
        for (int i = 0; i < DEPTH; i++) wr_cnt[i] = 0;
    endtask

    function automatic int total_writes();
        int s = 0;
        for (int i = 0; i < DEPTH; i++) s += wr_cnt[i];
        return s;
    endfunction

    initial begin
        int ones;
        for (int i = 0; i < DEPTH; i++) begin
            bram0[i] = $urandom;
            bram1[i] = '0;
        end
        clear_wr_cnt();

        // Reset held with i_run asserted must leave the mover idle.
        i_run = 1'b1;
        i_num_cnt = 13'd8;
        repeat (3) begin
            @(negedge clk);
            check("rst_idle", o_idle, 1);
            check("rst_outs", {o_read, o_write, o_done, ce_b0, ce_b1, we_b1}, 0);
            check("rst_addr", {addr_b0, addr_b1, d_b1}, 0);
        end
        reset = 1'b0;
        i_run = 1'b0;

        for (int i = 0; i < 8; i++) bram0[i] = 32'hA0 + i;
        run_xfer(8, 12'h000, 12'h100, 0, 32'h0, 0, 0);
        for (int i = 0; i < 8; i++) check("copy_mem", bram1[12'h100 + i], 32'hA0 + i);

        bram0[12'h010] = 32'hFFFF_FFFF;
        bram0[12'h011] = 32'h7;
        run_xfer(2, 12'h010, 12'h200, 1, 32'h1, 0, 0);
        check("add_wrap", bram1[12'h200], 32'h0);
        check("add_plain", bram1[12'h201], 32'h8);

        bram0[12'h020] = 32'h1234_5678;
        run_xfer(1, 12'h020, 12'h300, 2, 32'hFFFF_0000, 0, 0);
        check("xor_mem", bram1[12'h300], 32'hEDCB_5678);

        run_xfer(4, 4094, 4095, 3, 32'h0, 0, 0);
        run_xfer(0, 12'h123, 12'h456, 0, 32'h0, 0, 0);

        clear_wr_cnt();
        run_xfer(13'h1FFF, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), 1, $urandom, 0, 0);
        ones = 0;
        for (int i = 0; i < DEPTH; i++) if (wr_cnt[i] == 1) ones++;
        check("clamp_each_addr_once", ones, DEPTH);

        clear_wr_cnt();
        run_xfer(8, 12'h040, 12'h500, 0, 32'h0, 3, 0);
        check("busy_write_count", total_writes(), 8);

        clear_wr_cnt();
        run_xfer(8, 12'h040, 12'h600, 0, 32'h0, 0, 5);
        check("abort_write_count", total_writes(), 0);

        for (int t = 0; t < 20; t++)
            run_xfer((t % 5 == 0) ? $urandom_range(0, 3) : $urandom_range(1, 40),
                     $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                     $urandom_range(0, 3), $urandom, (t % 4 == 1) ? 2 : 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
